// File: rtl/csr_access_sequencer.sv
// Initiator side of the CSR register-file interface: sequences one Zicsr
// instruction at a time through read, optional write and response phases.
module csr_access_sequencer #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_func3,
   input  logic [ADDR_W-1:0] req_csr_address,
   input  logic [XLEN-1:0]   req_rs1_value,
   input  logic [4:0]        req_zimm,
   input  logic [4:0]        req_rd,
   output logic [ADDR_W-1:0] csr_address,
   input  logic [XLEN-1:0]   csr_read_data,
   output logic              csr_write_enable,
   output logic [XLEN-1:0]   csr_write_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [4:0]        rsp_rd,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_illegal
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]        state;
   logic [2:0]        func3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   rs1_q;
   logic [4:0]        zimm_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   new_q;
   logic              wen_q;
   logic [4:0]        rsp_rd_q;
   logic [XLEN-1:0]   rsp_data_q;
   logic              rsp_illegal_q;

   logic [XLEN-1:0]   operand;
   logic [XLEN-1:0]   new_value;
   logic              write_needed;
   logic              illegal_now;

   always_comb begin
      operand      = func3_q[2] ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;
      new_value    = '0;
      case (func3_q[1:0])
         2'b01:   new_value = operand;
         2'b10:   new_value = csr_read_data | operand;
         2'b11:   new_value = csr_read_data & ~operand;
         default: new_value = '0;
      endcase
      // Set/clear forms only write when the rs1 index / immediate field is nonzero.
      write_needed = (func3_q[1:0] == 2'b01) ||
                     ((func3_q[1:0] != 2'b00) && (zimm_q != 5'd0));
      illegal_now  = (func3_q[1:0] == 2'b00) ||
                     (write_needed && (addr_q[ADDR_W-1 -: 2] == 2'b11));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         func3_q       <= '0;
         addr_q        <= '0;
         rs1_q         <= '0;
         zimm_q        <= '0;
         rd_q          <= '0;
         new_q         <= '0;
         wen_q         <= 1'b0;
         rsp_rd_q      <= '0;
         rsp_data_q    <= '0;
         rsp_illegal_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  func3_q <= req_func3;
                  addr_q  <= req_csr_address;
                  rs1_q   <= req_rs1_value;
                  zimm_q  <= req_zimm;
                  rd_q    <= req_rd;
                  state   <= READ;
               end
            end
            READ: begin
               new_q         <= new_value;
               wen_q         <= write_needed && !illegal_now;
               rsp_rd_q      <= rd_q;
               rsp_data_q    <= illegal_now ? '0 : csr_read_data;
               rsp_illegal_q <= illegal_now;
               state         <= WRITE;
            end
            WRITE: state <= RESP;
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobe is gated by state so an async reset in WRITE drops it immediately.
   assign req_ready        = (state == IDLE) && reset;
   assign csr_address      = ((state == READ) || (state == WRITE)) ? addr_q : '0;
   assign csr_write_enable = (state == WRITE) && wen_q;
   assign csr_write_data   = csr_write_enable ? new_q : '0;
   assign rsp_valid        = (state == RESP);
   assign rsp_rd           = rsp_rd_q;
   assign rsp_data         = rsp_data_q;
   assign rsp_illegal      = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Scoreboard bench for csr_access_sequencer: a CSR array stands in for the
// CSR unit, a behavioural model predicts writes and responses.
module tb_csr_access_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_func3 = '0;
   logic [11:0] req_csr_address = '0;
   logic [31:0] req_rs1_value = '0;
   logic [4:0]  req_zimm = '0;
   logic [4:0]  req_rd = '0;
   logic [11:0] csr_address;
   logic [31:0] csr_read_data;
   logic        csr_write_enable;
   logic [31:0] csr_write_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data;
   logic        rsp_illegal;

   csr_access_sequencer #(.XLEN(32), .ADDR_W(12)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_func3(req_func3),
      .req_csr_address(req_csr_address), .req_rs1_value(req_rs1_value),
      .req_zimm(req_zimm), .req_rd(req_rd),
      .csr_address(csr_address), .csr_read_data(csr_read_data),
      .csr_write_enable(csr_write_enable), .csr_write_data(csr_write_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
      .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] seed(input int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
   endfunction

   // CSR unit stand-in
   logic        fill = 1'b1;
   logic        set_en = 1'b0;
   logic [11:0] set_addr = '0;
   logic [31:0] set_val = '0;
   logic [31:0] csr_mem [0:4095];
   assign csr_read_data = csr_mem[csr_address];
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 4096; i++) csr_mem[i] <= seed(i);
      end else if (csr_write_enable) csr_mem[csr_address] <= csr_write_data;
      else if (set_en) csr_mem[set_addr] <= set_val;
   end

   logic rand_rdy = 1'b0;
   logic rr_dir = 1'b1;
   logic rr_rand = 1'b1;
   always @(posedge clk) rr_rand <= ($urandom_range(0, 3) != 0);
   assign rsp_ready = rand_rdy ? rr_rand : rr_dir;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        ill;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      int          acc;
   } exp_t;

   function automatic exp_t model(input logic [2:0] f3, input logic [11:0] a,
                                  input logic [31:0] rs1, input logic [4:0] z,
                                  input logic [4:0] rd, input logic [31:0] old);
      exp_t e;
      logic [31:0] op;
      logic [31:0] nv;
      logic        writes;
      logic        ill;
      int          kind;
      kind   = int'(f3 % 4);
      op     = (f3 >= 3'd4) ? 32'(z) : rs1;
      nv     = (kind == 1) ? op : (kind == 2) ? (old | op) : (old & ~op);
      writes = (kind == 1) || (kind != 0 && z != 5'd0);
      ill    = (kind == 0) || (writes && a >= 12'hC00);
      e.rd    = rd;
      e.data  = ill ? 32'd0 : old;
      e.ill   = ill;
      e.wr    = writes && !ill;
      e.addr  = a;
      e.wdata = nv;
      e.acc   = 0;
      return e;
   endfunction

   // Reference model, scoreboard and monitor share one process.
   logic [31:0] ref_mem [0:4095];
   exp_t q[$];
   int   strobes = 0;
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (fill) for (int i = 0; i < 4096; i++) ref_mem[i] = seed(i);
      if (set_en) ref_mem[set_addr] = set_val;
      if (!reset) begin
         q.delete();
         strobes = 0;
         prev_valid = 1'b0;
      end else begin
         if (q.size() != 0 && ncyc == q[0].acc)
            check("read_addr", 32'(csr_address), 32'(q[0].addr));
         if (csr_write_enable) begin
            check("strobe_expected", 32'(q.size() != 0 && q[0].wr), 32'd1);
            if (q.size() != 0 && q[0].wr) begin
               check("strobe_cycle", 32'(ncyc), 32'(q[0].acc + 1));
               check("strobe_addr", 32'(csr_address), 32'(q[0].addr));
               check("strobe_data", csr_write_data, q[0].wdata);
               check("strobe_once", 32'(strobes), 32'd0);
               ref_mem[q[0].addr] = q[0].wdata;
            end
            strobes++;
         end
         if (rsp_valid) begin
            check("rsp_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               if (!prev_valid) check("rsp_latency", 32'(ncyc), 32'(q[0].acc + 2));
               check("rsp_rd", 32'(rsp_rd), 32'(q[0].rd));
               check("rsp_data", rsp_data, q[0].data);
               check("rsp_illegal", 32'(rsp_illegal), 32'(q[0].ill));
               check("resp_req_ready", 32'(req_ready), 32'd0);
               check("resp_csr_addr", 32'(csr_address), 32'd0);
               if (rsp_ready) begin
                  check("strobe_count", 32'(strobes), 32'(q[0].wr));
                  void'(q.pop_front());
                  strobes = 0;
               end
            end
         end
         prev_valid = rsp_valid;
         if (req_valid && req_ready) begin
            exp_t e;
            e = model(req_func3, req_csr_address, req_rs1_value, req_zimm, req_rd,
                      ref_mem[req_csr_address]);
            e.acc = ncyc + 1;
            q.push_back(e);
         end
      end
   end

   task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
      @(posedge clk); #1;
      set_en = 1'b1; set_addr = a; set_val = v;
      @(posedge clk); #1;
      set_en = 1'b0;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                        input logic [4:0] z, input logic [4:0] rd);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!req_ready && n < 100);
      check("issue_ready", 32'(req_ready), 32'd1);
      req_func3 = f3; req_csr_address = a; req_rs1_value = rs1;
      req_zimm = z; req_rd = rd; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || !req_ready) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      fill = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_csr_addr", 32'(csr_address), 32'd0);
      check("rst_wen", 32'(csr_write_enable), 32'd0);
      check("rst_wdata", csr_write_data, 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
      reset = 1'b1;
      #1;
      check("idle_req_ready", 32'(req_ready), 32'd1);

      set_csr(12'h340, 32'h12345678);
      issue(3'b001, 12'h340, 32'hDEADBEEF, 5'd2, 5'd5);
      wait_idle();
      issue(3'b010, 12'hC00, 32'hFFFFFFFF, 5'd0, 5'd7);
      wait_idle();
      set_csr(12'h340, 32'hFFFFFFFF);
      issue(3'b111, 12'h340, 32'h0, 5'h1F, 5'd3);
      wait_idle();
      set_csr(12'h341, 32'h00000010);
      issue(3'b110, 12'h341, 32'h0, 5'h05, 5'd4);
      wait_idle();
      issue(3'b001, 12'hC00, 32'h55AA55AA, 5'd1, 5'd8);
      wait_idle();
      issue(3'b000, 12'h300, 32'h1, 5'd1, 5'd9);
      wait_idle();

      // Response backpressure with a second request waiting.
      rr_dir = 1'b0;
      issue(3'b001, 12'h305, $urandom, 5'd6, 5'd10);
      for (int n = 0; n < 20 && !rsp_valid; n++) begin
         @(posedge clk); #1;
      end
      req_func3 = 3'b010; req_csr_address = 12'h305; req_rs1_value = 32'h0F0F0000;
      req_zimm = 5'd3; req_rd = 5'd11; req_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         check("stall_req_ready", 32'(req_ready), 32'd0);
         check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      rr_dir = 1'b1;
      @(posedge clk); #1;
      check("post_hs_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("second_accepted", 32'(req_ready), 32'd0);
      wait_idle();

      // Reset while the write strobe is high.
      issue(3'b001, 12'h340, 32'hA5A5A5A5, 5'd1, 5'd6);
      @(posedge clk); #1;
      check("wr_strobe_high", 32'(csr_write_enable), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_wen_drop", 32'(csr_write_enable), 32'd0);
      check("async_req_ready", 32'(req_ready), 32'd0);
      check("async_csr_addr", 32'(csr_address), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rel_req_ready", 32'(req_ready), 32'd1);
      issue(3'b001, 12'h340, 32'h0BADF00D, 5'd1, 5'd12);
      wait_idle();

      rand_rdy = 1'b1;
      for (int k = 0; k < 150; k++) begin
         logic [11:0] a;
         case ($urandom_range(0, 6))
            0: a = 12'h340;
            1: a = 12'h341;
            2: a = 12'h300;
            3: a = 12'hC00;
            4: a = 12'hC80;
            5: a = 12'hF11;
            default: a = 12'($urandom);
         endcase
         issue(3'($urandom_range(0, 7)), a, $urandom,
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               5'($urandom));
      end
      rand_rdy = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_access_sequencer.md
Name: csr_access_sequencer

Overview:
- Initiator side of the CSR register-file interface.
- Accepts one decoded Zicsr instruction at a time from the execute stage over a valid/ready handshake.
- Runs the read-modify-write sequence against the CSR unit: address, read data, write enable, write data.
- Returns the old CSR value for rd, plus an illegal-instruction flag for the trap logic.

Parameters:
- XLEN, 32, data width of CSR values and rs1 operand.
- ADDR_W, 12, CSR address width.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  execute stage presents a CSR instruction.
- req_ready  output  1  sequencer can accept; equals (state==IDLE && reset high).
- req_func3  input  3  instruction funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- req_csr_address  input  12  instruction bits 31:20.
- req_rs1_value  input  XLEN  rs1 register value.
- req_zimm  input  5  instruction bits 19:15; used as the rs1 index for reg forms and as uimm for I forms.
- req_rd  input  5  destination register index.
- csr_address  output  12  address to CSR unit.
- csr_read_data  input  XLEN  combinational read data from CSR unit.
- csr_write_enable  output  1  one-cycle write strobe.
- csr_write_data  output  XLEN  value to write.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  writeback accepts result.
- rsp_rd  output  5  latched rd.
- rsp_data  output  XLEN  old CSR value; 0 when illegal.
- rsp_illegal  output  1  illegal CSR instruction.

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (asserted low, async): state=IDLE; all latched fields and registered outputs cleared. While reset is low: req_ready=0, csr_address=0, csr_write_enable=0, csr_write_data=0, rsp_valid=0, rsp_rd=0, rsp_data=0, rsp_illegal=0.
- IDLE: req_ready=1. On req_valid && req_ready at a clock edge, latch func3, address, rs1 value, zimm and rd; go to READ. csr_address=0 in IDLE.
- READ (1 cycle): csr_address=latched address. At the edge, capture csr_read_data into old_value, compute new_value, write_needed and illegal; go to WRITE.
- Operand: func3[2]=1 gives {27'b0, zimm}; otherwise rs1_value.
- new_value by func3[1:0]:
  - 01: operand.
  - 10: old | operand.
  - 11: old & ~operand.
- write_needed: always for func3[1:0]=01. For 10/11 only when zimm != 0; this is the index/immediate field, not rs1_value.
- illegal when either holds:
  - func3[1:0]=00 (funct3 000 or 100);
  - write_needed && address[11:10]==2'b11 (read-only space).
- Reads of unimplemented addresses are legal and return whatever the CSR unit returns.
- WRITE (1 cycle): csr_address held. csr_write_enable = write_needed && !illegal. csr_write_data = new_value when enabled, else 0. Go to RESP.
- RESP: rsp_valid=1; rsp_rd, rsp_data (old_value, or 0 if illegal) and rsp_illegal are registered and stable. csr_address=0, no write.
  - rsp_valid && rsp_ready at an edge: go to IDLE.
  - rsp_ready low: hold indefinitely with all outputs stable.
- Latency: acceptance edge N; READ in cycle N+1; write strobe in cycle N+2; rsp_valid from cycle N+3.
- Throughput: one instruction per 4 cycles minimum.
- At most one csr_write_enable pulse per accepted instruction; never while illegal.
- Reset mid-operation: return to IDLE immediately. A strobe already high in WRITE drops asynchronously. The pending response is discarded.
- req inputs are ignored outside IDLE.

Test Plan:
- CSRRW addr 0x340, rs1_value 0xDEADBEEF, rd=5, CSR model holds 0x12345678 -> write_enable exactly one cycle at N+2 with data 0xDEADBEEF; rsp at N+3 with rd=5, data 0x12345678, illegal=0.
- CSRRS addr 0xC00, zimm(rs1 idx)=0, rs1_value 0xFFFFFFFF -> no write strobe; rsp_data = model value; illegal=0.
- CSRRCI addr 0x340, zimm=0x1F, old 0xFFFFFFFF -> write data 0xFFFFFFE0. CSRRSI zimm=0x05 on old 0x00000010 -> write data 0x00000015.
- CSRRW to 0xC00 -> rsp_illegal=1, rsp_data=0, no strobe. funct3=000 -> illegal=1, no strobe.
- rsp_ready held low 3 cycles -> rsp_valid, rsp_data and rsp_rd stable, req_ready=0, second req_valid not accepted; accepted the cycle after the rsp handshake.
- reset pulled low during WRITE -> csr_write_enable falls without a clock, state returns to IDLE, rsp_valid never asserts. After reset release, req_ready=1 and a new CSRRW completes normally.
